// File: rtl/mii_tx_framer_pkg.sv
// Shared constants, state encoding and nibble-wide CRC-32 step for the MII TX framer.
package mii_tx_framer_pkg;

    localparam int BUF_WORDS = 256;
    localparam int MAX_LEN   = 1514;
    localparam int MIN_LEN   = 60;
    localparam int IFG_NIB   = 24;

    localparam logic [14:0] TXBUFF_OFFSET = 15'h1000;
    localparam logic [14:0] TPLR_OFFSET   = 15'h0808;
    localparam logic [14:0] TSR_OFFSET    = 15'h0810;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    // Reflected CRC: nibble bit 0 is the first bit on the wire.
    function automatic logic [31:0] crc32_nib(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc ^ {28'h0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mii_tx_framer_if.sv
// core_lsu bus as seen by the TX framer: address/data/strobes in, registered read data out.
interface mii_tx_framer_if;
    logic [14:0] core_lsu_addr;
    logic [63:0] core_lsu_wdata;
    logic [7:0]  core_lsu_be;
    logic        ce_d;
    logic        we_d;
    logic [63:0] framing_rdata;

    modport master (
        output core_lsu_addr, core_lsu_wdata, core_lsu_be, ce_d, we_d,
        input  framing_rdata
    );

    modport slave (
        input  core_lsu_addr, core_lsu_wdata, core_lsu_be, ce_d, we_d,
        output framing_rdata
    );
endinterface

// File: rtl/mii_tx_framer_crc32_nibble.sv
// Registered CRC-32 accumulator, one nibble per enabled clock; clear wins over enable.
module crc32_nibble
    import mii_tx_framer_pkg::*;
(
    input  logic        clk_mii,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [3:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk_mii) begin
        if (reset || clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_nib(crc, data);
        end
    end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: bus-writable TX buffer plus a nibble serialiser with pad and FCS.
// state    | meaning
// IDLE     | waiting for a valid TPLR write
// PREAMBLE | 15 nibbles of 0x5
// SFD      | 0xD nibble, word 0 fetched
// DATA     | payload nibbles, low nibble first, next word fetched on nibble 15
// PAD      | zero nibbles up to MIN_LEN bytes
// FCS      | ~crc, low nibble first
// IFG      | TX enable low, busy held until exit
module mii_tx_framer
    import mii_tx_framer_pkg::*;
(
    input  logic           clk_mii,
    input  logic           reset,
    mii_tx_framer_if.slave bus,
    output logic [3:0]     o_etxd,
    output logic           o_etx_en,
    output logic           o_etx_er,
    output logic           tx_irq
);

    logic [63:0] mem [BUF_WORDS];

    tx_state_t   state;
    logic [11:0] cnt;
    logic        busy;
    logic        len_err;
    logic [10:0] tplr_len;
    logic [7:0]  widx;
    logic [3:0]  nib_pos;
    logic [63:0] data_sr;
    logic [31:0] crc;

    logic [7:0]  bus_idx;
    logic [7:0]  rd_idx;
    logic [63:0] rd_data;
    logic        in_buf;
    logic        bus_rd;
    logic        buf_wr;
    logic        tplr_wr;
    logic        eng_rd;
    logic [10:0] wlen;
    logic        len_bad;
    logic [31:0] fcs_word;
    logic [2:0]  fcs_sel;
    logic [3:0]  fcs_nib;
    logic [11:0] pad_nibs;
    logic        crc_en;
    logic        crc_clr;
    logic [3:0]  crc_din;

    assign o_etx_er = 1'b0;

    assign bus_idx = bus.core_lsu_addr[3 +: 8];
    assign in_buf  = (bus.core_lsu_addr[14:11] == TXBUFF_OFFSET[14:11]);
    assign bus_rd  = bus.ce_d && !bus.we_d;
    assign buf_wr  = bus.ce_d && bus.we_d && in_buf && !busy;
    assign tplr_wr = bus.ce_d && bus.we_d && (bus.core_lsu_addr == TPLR_OFFSET)
                     && (bus.core_lsu_be[1:0] == 2'b11);
    assign wlen    = bus.core_lsu_wdata[10:0];
    assign len_bad = (wlen == 11'd0) || (wlen > 11'(MAX_LEN));

    // Single read port: the engine's prefetch steals it from the bus when both want it.
    assign eng_rd  = (state == SFD) || ((state == DATA) && (nib_pos == 4'hF));
    assign rd_idx  = eng_rd ? widx : bus_idx;
    assign rd_data = mem[rd_idx];

    assign fcs_word = ~crc;
    assign fcs_sel  = 3'd7 - cnt[2:0];
    assign fcs_nib  = fcs_word[{fcs_sel, 2'b00} +: 4];
    assign pad_nibs = {11'(MIN_LEN) - tplr_len, 1'b0};

    assign crc_clr = (state == IDLE);
    assign crc_en  = (state == DATA) || (state == PAD);
    assign crc_din = (state == DATA) ? data_sr[3:0] : 4'h0;

    crc32_nibble u_crc (
        .clk_mii (clk_mii),
        .reset   (reset),
        .clear   (crc_clr),
        .en      (crc_en),
        .data    (crc_din),
        .crc     (crc)
    );

    always_ff @(posedge clk_mii) begin
        if (buf_wr) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.core_lsu_be[i]) begin
                    mem[bus_idx][8*i +: 8] <= bus.core_lsu_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_mii) begin
        if (reset) begin
            bus.framing_rdata <= '0;
        end else if (bus_rd) begin
            if (in_buf) begin
                if (!eng_rd) begin
                    bus.framing_rdata <= rd_data;
                end
            end else if (bus.core_lsu_addr == TSR_OFFSET) begin
                bus.framing_rdata <= {62'h0, len_err, busy};
            end else if (bus.core_lsu_addr == TPLR_OFFSET) begin
                bus.framing_rdata <= {53'h0, tplr_len};
            end else begin
                bus.framing_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk_mii) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            len_err  <= 1'b0;
            tplr_len <= '0;
            widx     <= '0;
            nib_pos  <= '0;
            data_sr  <= '0;
            o_etxd   <= '0;
            o_etx_en <= 1'b0;
            tx_irq   <= 1'b0;
        end else begin
            tx_irq <= 1'b0;
            case (state)
                IDLE: begin
                    o_etx_en <= 1'b0;
                    o_etxd   <= '0;
                    if (tplr_wr) begin
                        if (len_bad) begin
                            len_err <= 1'b1;
                        end else begin
                            len_err  <= 1'b0;
                            busy     <= 1'b1;
                            tplr_len <= wlen;
                            widx     <= '0;
                            cnt      <= 12'd14;
                            state    <= PREAMBLE;
                        end
                    end
                end
                PREAMBLE: begin
                    o_etx_en <= 1'b1;
                    o_etxd   <= PREAMBLE_NIB;
                    if (cnt == 12'd0) begin
                        state <= SFD;
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                SFD: begin
                    o_etxd  <= SFD_NIB;
                    data_sr <= rd_data;
                    widx    <= widx + 8'd1;
                    nib_pos <= '0;
                    cnt     <= {tplr_len, 1'b0} - 12'd1;
                    state   <= DATA;
                end
                DATA: begin
                    o_etxd  <= data_sr[3:0];
                    nib_pos <= nib_pos + 4'd1;
                    if (nib_pos == 4'hF) begin
                        data_sr <= rd_data;
                        widx    <= widx + 8'd1;
                    end else begin
                        data_sr <= {4'h0, data_sr[63:4]};
                    end
                    if (cnt == 12'd0) begin
                        if (tplr_len < 11'(MIN_LEN)) begin
                            cnt   <= pad_nibs - 12'd1;
                            state <= PAD;
                        end else begin
                            cnt   <= 12'd7;
                            state <= FCS;
                        end
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                PAD: begin
                    o_etxd <= 4'h0;
                    if (cnt == 12'd0) begin
                        cnt   <= 12'd7;
                        state <= FCS;
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                FCS: begin
                    o_etxd <= fcs_nib;
                    if (cnt == 12'd0) begin
                        cnt   <= 12'(IFG_NIB - 1);
                        state <= IFG;
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                IFG: begin
                    o_etx_en <= 1'b0;
                    o_etxd   <= '0;
                    tx_irq   <= (cnt == 12'(IFG_NIB - 1));
                    if (cnt == 12'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: frames are captured off the MII pins and checked against a byte model.
module tb_mii_tx_framer;

    localparam logic [14:0] A_BUF  = 15'h1000;
    localparam logic [14:0] A_TPLR = 15'h0808;
    localparam logic [14:0] A_TSR  = 15'h0810;

    logic       clk_mii = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] o_etxd;
    logic       o_etx_en;
    logic       o_etx_er;
    logic       tx_irq;

    mii_tx_framer_if bus ();

    mii_tx_framer dut (
        .clk_mii  (clk_mii),
        .reset    (reset),
        .bus      (bus),
        .o_etxd   (o_etxd),
        .o_etx_en (o_etx_en),
        .o_etx_er (o_etx_er),
        .tx_irq   (tx_irq)
    );

    always #5 clk_mii = ~clk_mii;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mdl [0:2047];
    logic [3:0] cap [0:4095];
    logic [63:0] rd;
    logic [63:0] w;
    int          seen;
    int          guard;
    int          en_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc_nib(input logic [31:0] c_in, input logic [3:0] n);
        logic [31:0] c;
        c = c_in ^ {28'h0, n};
        for (int i = 0; i < 4; i++) begin
            if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
            else      c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    task automatic bus_write(input logic [14:0] a, input logic [63:0] d, input logic [7:0] be);
        @(negedge clk_mii);
        bus.core_lsu_addr  = a;
        bus.core_lsu_wdata = d;
        bus.core_lsu_be    = be;
        bus.ce_d           = 1'b1;
        bus.we_d           = 1'b1;
        @(negedge clk_mii);
        bus.ce_d = 1'b0;
        bus.we_d = 1'b0;
    endtask

    task automatic bus_read(input logic [14:0] a, output logic [63:0] d);
        @(negedge clk_mii);
        bus.core_lsu_addr = a;
        bus.ce_d          = 1'b1;
        bus.we_d          = 1'b0;
        @(negedge clk_mii);
        bus.ce_d = 1'b0;
        d = bus.framing_rdata;
    endtask

    task automatic wr_buf(input int idx, input logic [63:0] d, input logic [7:0] be);
        bus_write(A_BUF + 15'(idx * 8), d, be);
        for (int j = 0; j < 8; j++) begin
            if (be[j]) mdl[idx*8 + j] = d[8*j +: 8];
        end
    endtask

    function automatic logic [63:0] mdl_word(input int idx);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = mdl[idx*8 + j];
        return r;
    endfunction

    task automatic capture(output int n_en, output int n_irq, output logic irq_fall);
        int g;
        n_en = 0; n_irq = 0; irq_fall = 1'b0; g = 0;
        while (!o_etx_en && g < 20) begin
            @(negedge clk_mii);
            g++;
        end
        while (o_etx_en && g < 4000) begin
            cap[n_en] = o_etxd;
            n_en++;
            if (tx_irq) n_irq++;
            @(negedge clk_mii);
            g++;
        end
        irq_fall = tx_irq;
        if (tx_irq) n_irq++;
        @(negedge clk_mii);
        if (tx_irq) n_irq++;
    endtask

    task automatic check_frame(input string tag, input int len, input int exp_n);
        int          n_en;
        int          n_irq;
        logic        irq_fall;
        int          bad;
        logic [31:0] c;
        capture(n_en, n_irq, irq_fall);
        check({tag, "_en_cycles"}, 64'(n_en), 64'(exp_n));
        bad = 0;
        for (int i = 0; i < 15; i++) if (cap[i] !== 4'h5) bad++;
        check({tag, "_preamble_bad"}, 64'(bad), 64'd0);
        check({tag, "_sfd"}, 64'(cap[15]), 64'hD);
        bad = 0;
        for (int k = 0; k < len && 17 + 2*k < 4096; k++) begin
            if (cap[16 + 2*k] !== mdl[k][3:0]) bad++;
            if (cap[17 + 2*k] !== mdl[k][7:4]) bad++;
        end
        check({tag, "_data_bad"}, 64'(bad), 64'd0);
        bad = 0;
        for (int i = 16 + 2*len; i < n_en - 8 && i < 4096; i++) if (cap[i] !== 4'h0) bad++;
        check({tag, "_pad_bad"}, 64'(bad), 64'd0);
        c = 32'hFFFFFFFF;
        for (int i = 16; i < n_en && i < 4096; i++) c = ref_crc_nib(c, cap[i]);
        check({tag, "_residue"}, 64'(bitrev32(c)), 64'hC704DD7B);
        check({tag, "_irq_count"}, 64'(n_irq), 64'd1);
        check({tag, "_irq_at_fall"}, 64'(irq_fall), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_en;
        int   n_irq;
        logic irq_fall;
        bus.core_lsu_addr  = '0;
        bus.core_lsu_wdata = '0;
        bus.core_lsu_be    = '0;
        bus.ce_d           = 1'b0;
        bus.we_d           = 1'b0;
        for (int i = 0; i < 2048; i++) mdl[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_mii);
        check("rst_etx_en", 64'(o_etx_en), 64'd0);
        check("rst_etxd",   64'(o_etxd),   64'd0);
        check("rst_etx_er", 64'(o_etx_er), 64'd0);
        check("rst_irq",    64'(tx_irq),   64'd0);
        check("rst_rdata",  bus.framing_rdata, 64'd0);
        reset = 1'b0;
        bus_read(A_TSR, rd);
        check("rst_tsr", rd, 64'd0);

        // 64-byte frame, bytes 0x00..0x3F
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(i*8 + j);
            wr_buf(i, w, 8'hFF);
        end
        bus_write(A_TPLR, 64'd64, 8'h03);
        check_frame("f64", 64, 152);
        bus_read(A_TSR, rd);
        check("f64_tsr_busy_in_ifg", rd, 64'h1);
        repeat (19) @(negedge clk_mii);
        bus_read(A_TSR, rd);
        check("f64_tsr_after_ifg", rd, 64'h0);

        // 10-byte frame padded to 60
        wr_buf(0, 64'h0807060504030201, 8'hFF);
        wr_buf(1, 64'h0000000000000A09, 8'hFF);
        bus_write(A_TPLR, 64'd10, 8'h03);
        check_frame("f10", 10, 144);
        check("f10_nib0",  64'(cap[16]), 64'h1);
        check("f10_nib1",  64'(cap[17]), 64'h0);
        check("f10_nib18", 64'(cap[34]), 64'hA);
        check("f10_pad0",  64'(cap[36]), 64'h0);
        repeat (30) @(negedge clk_mii);

        // Length errors, then a valid boundary length
        bus_write(A_TPLR, 64'd0, 8'h03);
        en_cnt = 0;
        repeat (5) begin
            @(negedge clk_mii);
            if (o_etx_en) en_cnt++;
        end
        check("len0_no_tx", 64'(en_cnt), 64'd0);
        bus_read(A_TSR, rd);
        check("len0_tsr", rd, 64'h2);
        bus_write(A_TPLR, 64'd1515, 8'h03);
        en_cnt = 0;
        repeat (5) begin
            @(negedge clk_mii);
            if (o_etx_en) en_cnt++;
        end
        check("len1515_no_tx", 64'(en_cnt), 64'd0);
        bus_read(A_TSR, rd);
        check("len1515_tsr", rd, 64'h2);
        bus_write(A_TPLR, 64'd60, 8'h03);
        check_frame("f60", 60, 144);
        repeat (30) @(negedge clk_mii);
        bus_read(A_TSR, rd);
        check("f60_tsr", rd, 64'h0);

        // TPLR and buffer writes while busy are dropped
        bus_write(A_TPLR, 64'd64, 8'h03);
        fork
            check_frame("fbusy", 64, 152);
            begin
                repeat (20) @(negedge clk_mii);
                bus_write(A_TPLR, 64'd100, 8'h03);
                bus_write(A_BUF + 15'h0010, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
            end
        join
        repeat (30) @(negedge clk_mii);
        bus_read(A_BUF + 15'h0010, rd);
        check("busy_word2_kept", rd, mdl_word(2));
        bus_read(A_TPLR, rd);
        check("busy_tplr_kept", rd, 64'd64);

        // Partial byte-enable write
        wr_buf(20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        wr_buf(20, 64'hAABBCCDD11223344, 8'h0F);
        bus_read(A_BUF + 15'(20 * 8), rd);
        check("be_partial", rd, 64'hFFFFFFFF11223344);
        bus_read(15'h0100, rd);
        check("unmapped_zero", rd, 64'd0);

        // Reset while DATA nibble 40 is on the pins
        bus_write(A_TPLR, 64'd64, 8'h03);
        seen = 0;
        guard = 0;
        while (seen < 57 && guard < 200) begin
            @(negedge clk_mii);
            guard++;
            if (o_etx_en) seen++;
        end
        check("midrst_reached", 64'(seen), 64'd57);
        reset = 1'b1;
        @(negedge clk_mii);
        check("midrst_en_drop", 64'(o_etx_en), 64'd0);
        reset = 1'b0;
        bus_read(A_TSR, rd);
        check("midrst_tsr", rd, 64'h0);
        bus_write(A_TPLR, 64'd64, 8'h03);
        check_frame("fafter", 64, 152);
        repeat (30) @(negedge clk_mii);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
